// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues in-order word fetches, tags each request with
// its PC, buffers returned {pc, inst} pairs for decode, and drops wrong-path
// responses after a redirect from execute.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] pc_out,
   output logic [31:0] inst_out
);

   localparam int          CW      = $clog2(DEPTH + 1);
   localparam int          PW      = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic [31:0]   fetch_pc;
   logic          run;

   logic [31:0]   tag_mem [DEPTH];
   logic [PW-1:0] tag_wr;
   logic [PW-1:0] tag_rd;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;

   logic [31:0]   ib_pc   [DEPTH];
   logic [31:0]   ib_inst [DEPTH];
   logic [PW-1:0] ib_wr;
   logic [PW-1:0] ib_rd;
   logic [CW-1:0] ib_count;

   logic          req_fire;
   logic          rsp_fire;
   logic          rsp_keep;
   logic          ib_pop;
   logic          ib_empty;
   logic          credit_ok;
   logic          unused_redirect_lsbs;

   // Ring pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Every request in flight or buffered holds one slot, so the buffer can never overflow.
   assign credit_ok      = ({1'b0, outstanding} + {1'b0, ib_count}) < DEPTH_C;
   assign imem_req_valid = run && !redirect_valid && credit_ok;
   assign imem_addr      = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is ignored; responses in a redirect
   // cycle or while drop_cnt is non-zero belong to the wrong path.
   assign rsp_fire = imem_rsp_valid && (outstanding != '0);
   assign rsp_keep = rsp_fire && (drop_cnt == '0) && !redirect_valid;

   assign ib_empty = (ib_count == '0);
   assign if_valid = !ib_empty && !redirect_valid;
   assign ib_pop   = if_valid && id_ready;
   assign pc_out   = ib_empty ? 32'h0 : ib_pc[ib_rd];
   assign inst_out = ib_empty ? NOP   : ib_inst[ib_rd];

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Fetch PC and run flag: redirect wins over sequential advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run      <= 1'b0;
         fetch_pc <= RESET_PC;
      end else begin
         run <= 1'b1;
         if (redirect_valid)
            fetch_pc <= {redirect_pc[31:2], 2'b00};
         else if (req_fire)
            fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // Tag FIFO pointers, in-flight count and wrong-path drop count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_wr      <= '0;
         tag_rd      <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         if (req_fire)
            tag_wr <= ptr_inc(tag_wr);
         if (rsp_fire)
            tag_rd <= ptr_inc(tag_rd);
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
         if (redirect_valid)
            drop_cnt <= outstanding - CW'(rsp_fire);
         else if (rsp_fire && (drop_cnt != '0))
            drop_cnt <= drop_cnt - CW'(1);
      end
   end

   // Tag storage: PC of each accepted request, read back when its word returns.
   always_ff @(posedge clk) begin
      if (req_fire)
         tag_mem[tag_wr] <= fetch_pc;
   end

   // Instruction buffer pointers and occupancy; a redirect empties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ib_wr    <= '0;
         ib_rd    <= '0;
         ib_count <= '0;
      end else if (redirect_valid) begin
         ib_wr    <= '0;
         ib_rd    <= '0;
         ib_count <= '0;
      end else begin
         if (rsp_keep)
            ib_wr <= ptr_inc(ib_wr);
         if (ib_pop)
            ib_rd <= ptr_inc(ib_rd);
         ib_count <= ib_count + CW'(rsp_keep) - CW'(ib_pop);
      end
   end

   // Instruction buffer storage: returned word paired with its request PC.
   always_ff @(posedge clk) begin
      if (rsp_keep) begin
         ib_pc[ib_wr]   <= tag_mem[tag_rd];
         ib_inst[ib_wr] <= imem_rsp_data;
      end
   end

   // Memory must never return a word that was not requested.
   rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: latency-configurable in-order memory model, expected
// program-order stream per reset/redirect, and a monitor that pops and compares.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_ready = 1'b0;
   logic        if_valid;
   logic [31:0] pc_out;
   logic [31:0] inst_out;

   inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .pc_out         (pc_out),
      .inst_out       (inst_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_acc    = 0;
   int n_pops   = 0;
   int tot_pops = 0;
   int mem_lat  = 1;

   typedef struct packed {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mem_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr  = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Program order from a start address: start, start+4, ... wrapping mod 2^32.
   task automatic load_stream(input logic [31:0] start);
      logic [31:0] pc;
      exp_q.delete();
      pc = {start[31:2], 2'b00};
      for (int i = 0; i < 1000; i++) begin
         exp_q.push_back(pc);
         pc = pc + 32'd4;
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: capture accepted requests, answer in order after mem_lat cycles.
   always @(negedge clk) begin
      mreq_t r;
      if (rst_n && imem_req_valid && imem_req_ready) begin
         r.addr = imem_addr;
         r.due  = cyc + mem_lat;
         mem_q.push_back(r);
         n_acc++;
      end
   end

   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         imem_rsp_valid = 1'b0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_q[0].addr ^ KEY;
         mem_q.delete(0);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   end

   // Monitor: every handshake to decode must be the next program-order instruction.
   always @(negedge clk) begin
      if (rst_n && if_valid && id_ready) begin
         n_pops++;
         tot_pops++;
         if (exp_q.size() == 0) begin
            check("stream_exhausted", 32'h1, 32'h0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("pc_out", pc_out, mon_exp);
            check("inst_out", inst_out, mon_exp ^ KEY);
         end
      end
   end

   // Request address must hold while valid and not accepted.
   always @(negedge clk) begin
      if (rst_n && prev_stall) check("addr_hold", imem_addr, prev_addr);
      prev_stall = rst_n && imem_req_valid && !imem_req_ready;
      prev_addr  = imem_addr;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      mem_q.delete();
      load_stream(RESET_PC);
      #1;
      check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_if_valid", {31'h0, if_valid}, 32'h0);
      check("rst_pc_out", pc_out, 32'h0);
      check("rst_inst_out", inst_out, NOP);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n  = 1'b1;
      n_acc  = 0;
      n_pops = 0;
      #1;
      check("req_before_run", {31'h0, imem_req_valid}, 32'h0);
      @(negedge clk);
      check("first_req", {31'h0, imem_req_valid}, 32'h1);
      check("first_addr", imem_addr, RESET_PC);
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      load_stream(pc);
   endtask

   initial begin
      int p0;
      int k;
      logic [31:0] tgt;

      id_ready       = 1'b1;
      imem_req_ready = 1'b1;
      mem_lat        = 1;
      do_reset();
      step();

      // Streaming from reset, then steady-state throughput.
      repeat (10) step();
      p0 = n_pops;
      repeat (20) step();
      check("throughput", 32'(n_pops - p0), 32'd20);

      // Decode stall: issue stops with DEPTH fetches held.
      id_ready = 1'b0;
      repeat (10) step();
      check("stall_credit", 32'(n_acc - n_pops), 32'(DEPTH));
      check("stall_no_issue", {31'h0, imem_req_valid}, 32'h0);
      id_ready = 1'b1;
      repeat (20) step();

      // Redirect latency with L=1.
      redirect_to(32'h0000_0040);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("redir_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("redir_req_addr", imem_addr, 32'h0000_0040);
      k = 1;
      while (!if_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("redir_latency", 32'(k), 32'd3);
      step();
      repeat (10) step();

      // Redirect with responses in flight at L=3.
      mem_lat = 3;
      repeat (15) step();
      redirect_to(32'h0000_0103);
      step();
      redirect_valid = 1'b0;
      repeat (20) step();

      // Back-to-back redirects.
      redirect_to(32'h0000_0200);
      step();
      redirect_to(32'h0000_0300);
      step();
      redirect_valid = 1'b0;
      repeat (20) step();

      // Address wrap.
      mem_lat = 1;
      redirect_to(32'hFFFF_FFF8);
      step();
      redirect_valid = 1'b0;
      repeat (12) step();

      // Random backpressure, latency, stalls and redirects, with a reset mid-stream.
      for (int c = 0; c < 600; c++) begin
         if (c == 300) begin
            do_reset();
            step();
         end
         imem_req_ready = ($urandom_range(0, 3) != 0);
         id_ready       = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 15) == 0) mem_lat = $urandom_range(1, 4);
         if ($urandom_range(0, 19) == 0) begin
            tgt = $urandom;
            redirect_to(tgt);
         end else begin
            redirect_valid = 1'b0;
         end
         step();
      end
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      repeat (20) step();

      check("progress", {31'h0, tot_pops > 100}, 32'h1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
